// File: rtl/seg7_capture.sv
// seg7_capture: receive side of the BCD-to-7-segment drive path.
// Samples a time-multiplexed 7-segment bus (segments plus one-hot digit
// selects), waits for each pattern to be stable, decodes it back to BCD
// per digit and pulses frame_valid once every digit has been captured.
// Optional feature macro: SEG7_CAPTURE_DP_EN adds the decimal point
// input seg_dp and the per-digit dp_out register.
module seg7_capture #(
   parameter int DIGITS     = 4,
   parameter int STABLE_CNT = 3,
   parameter int CNT_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  clr,
   input  logic [6:0]            seg_in,
`ifdef SEG7_CAPTURE_DP_EN
   input  logic                  seg_dp,
   output logic [DIGITS-1:0]     dp_out,
`endif
   input  logic [DIGITS-1:0]     dig_sel,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     blank_out,
   output logic [DIGITS-1:0]     err_out,
   output logic                  frame_valid
);

`ifdef SEG7_CAPTURE_DP_EN
   localparam int SEG_W = 8;
`else
   localparam int SEG_W = 7;
`endif

   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]  STABLE  = CNT_W'(STABLE_CNT);
   localparam logic [DIGITS-1:0] DIG_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_LATCHED} state_t;

   logic [SEG_W-1:0]        w_segBus;
   logic [SEG_W-1:0]        r_segMeta;
   logic [SEG_W-1:0]        r_segSync;
   logic [DIGITS-1:0]       r_digMeta;
   logic [DIGITS-1:0]       r_digSync;
   logic [DIGITS+SEG_W-1:0] w_sample;
   logic [DIGITS+SEG_W-1:0] r_prevSample;
   logic [DIGITS-1:0]       r_mask;
   logic [DIGITS-1:0]       w_maskNew;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        w_cntNext;
   state_t                  r_state;
   state_t                  w_stateNext;
   logic                    w_oneHot;
   logic                    w_same;
   logic                    w_write;
   logic                    w_frameDone;
   logic [3:0]              w_bcd;
   logic                    w_blank;
   logic                    w_err;

`ifdef SEG7_CAPTURE_DP_EN
   assign w_segBus = {seg_dp, seg_in};
`else
   assign w_segBus = seg_in;
`endif

   assign w_sample    = {r_digSync, r_segSync};
   assign w_same      = (w_sample == r_prevSample);
   assign w_oneHot    = (r_digSync != '0) && ((r_digSync & (r_digSync - DIG_ONE)) == '0);
   assign w_maskNew   = r_mask | r_digSync;
   assign w_frameDone = w_write && (w_maskNew == '1);

   // Two-flop synchronizer for the bus; runs every cycle regardless of en.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_segMeta <= '0;
         r_segSync <= '0;
         r_digMeta <= '0;
         r_digSync <= '0;
      end else begin
         r_segMeta <= w_segBus;
         r_segSync <= r_segMeta;
         r_digMeta <= dig_sel;
         r_digSync <= r_digMeta;
      end
   end

   // Map the synchronized 7-bit pattern back to BCD, blank or illegal.
   always_comb begin
      w_bcd   = 4'hE;
      w_blank = 1'b0;
      w_err   = 1'b0;
      case (r_segSync[6:0])
         7'b0111111: w_bcd = 4'd0;
         7'b0000110: w_bcd = 4'd1;
         7'b1011011: w_bcd = 4'd2;
         7'b1001111: w_bcd = 4'd3;
         7'b1100110: w_bcd = 4'd4;
         7'b1101101: w_bcd = 4'd5;
         7'b1111101: w_bcd = 4'd6;
         7'b0000111: w_bcd = 4'd7;
         7'b1111111: w_bcd = 4'd8;
         7'b1100111: w_bcd = 4'd9;
         7'b0000000: begin
            w_bcd   = 4'hF;
            w_blank = 1'b1;
         end
         default: begin
            w_bcd = 4'hE;
            w_err = 1'b1;
         end
      endcase
   end

   // Stability tracking: decide next state, next count and whether this
   // enabled sample is the one that commits the digit.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_write     = 1'b0;
      if (!w_oneHot) begin
         w_stateNext = S_IDLE;
         w_cntNext   = '0;
      end else if ((r_state == S_IDLE) || !w_same) begin
         w_cntNext = CNT_ONE;
         if (STABLE == CNT_ONE) begin
            w_write     = 1'b1;
            w_stateNext = S_LATCHED;
         end else begin
            w_stateNext = S_SETTLE;
         end
      end else if (r_state == S_SETTLE) begin
         w_cntNext = (r_cnt < STABLE) ? (r_cnt + CNT_ONE) : r_cnt;
         if (w_cntNext == STABLE) begin
            w_write     = 1'b1;
            w_stateNext = S_LATCHED;
         end
      end
   end

   // Capture FSM, captured-digit mask and registered outputs; clr wins
   // over a coincident write and en low freezes everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_mask       <= '0;
         r_prevSample <= '0;
         bcd_out      <= '0;
         blank_out    <= '0;
         err_out      <= '0;
         frame_valid  <= 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
         dp_out       <= '0;
`endif
      end else if (clr) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_mask      <= '0;
         bcd_out     <= '0;
         blank_out   <= '0;
         err_out     <= '0;
         frame_valid <= 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
         dp_out      <= '0;
`endif
      end else if (en) begin
         r_prevSample <= w_sample;
         r_state      <= w_stateNext;
         r_cnt        <= w_cntNext;
         frame_valid  <= w_frameDone;
         if (w_write) begin
            r_mask <= w_frameDone ? '0 : w_maskNew;
            for (int i = 0; i < DIGITS; i++) begin
               if (r_digSync[i]) begin
                  bcd_out[4*i +: 4] <= w_bcd;
                  blank_out[i]      <= w_blank;
                  err_out[i]        <= w_err;
`ifdef SEG7_CAPTURE_DP_EN
                  dp_out[i]         <= r_segSync[7];
`endif
               end
            end
         end
      end else begin
         frame_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed scoreboard bench for seg7_capture with the
// default parameters (4 digits, 3 stable samples).
module tb_seg7_capture;

   localparam logic [6:0] SEG0 = 7'b0111111;
   localparam logic [6:0] SEG1 = 7'b0000110;
   localparam logic [6:0] SEG2 = 7'b1011011;
   localparam logic [6:0] SEG3 = 7'b1001111;
   localparam logic [6:0] SEG4 = 7'b1100110;
   localparam logic [6:0] SEG5 = 7'b1101101;
   localparam logic [6:0] SEG6 = 7'b1111101;
   localparam logic [6:0] SEG7 = 7'b0000111;
   localparam logic [6:0] SEG8 = 7'b1111111;
   localparam logic [6:0] SEG9 = 7'b1100111;

   typedef struct {
      string       tag;
      logic [15:0] bcd;
      logic [3:0]  blank;
      logic [3:0]  err;
      logic        fvNow;
      int          fvTotal;
   } expT;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        clr;
   logic [6:0]  seg_in;
   logic [3:0]  dig_sel;
   logic [15:0] bcd_out;
   logic [3:0]  blank_out;
   logic [3:0]  err_out;
   logic        frame_valid;
`ifdef SEG7_CAPTURE_DP_EN
   logic        seg_dp = 1'b0;
   logic [3:0]  dp_out;
`endif

   expT         sbQueue[$];
   logic [15:0] expBcd   = '0;
   logic [3:0]  expBlank = '0;
   logic [3:0]  expErr   = '0;
   logic [3:0]  expMask  = '0;
   int          expFvDone = 0;
   int          fvSeen    = 0;
   int          testCount = 0;
   int          failCount = 0;
   logic        doneFlag;

   seg7_capture dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .clr         (clr),
      .seg_in      (seg_in),
`ifdef SEG7_CAPTURE_DP_EN
      .seg_dp      (seg_dp),
      .dp_out      (dp_out),
`endif
      .dig_sel     (dig_sel),
      .bcd_out     (bcd_out),
      .blank_out   (blank_out),
      .err_out     (err_out),
      .frame_valid (frame_valid)
   );

   // 100 MHz style clock, posedge at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Count frame_valid pulses half a cycle after they are launched.
   always @(negedge clk) begin
      if (frame_valid === 1'b1) fvSeen++;
   end

   // Runaway guard.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 100000ns");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference decode: returns {blank, err, nibble}.
   function automatic logic [5:0] decodeRef(input logic [6:0] s);
      logic [6:0] table_[10];
      table_ = '{SEG0, SEG1, SEG2, SEG3, SEG4, SEG5, SEG6, SEG7, SEG8, SEG9};
      if (s == 7'b0000000) return {2'b10, 4'hF};
      for (int k = 0; k < 10; k++) begin
         if (table_[k] == s) return {2'b00, 4'(k)};
      end
      return {2'b01, 4'hE};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] dig, input logic [6:0] seg);
      dig_sel = dig;
      seg_in  = seg;
   endtask

   // Reference model of a committed capture of digit d.
   task automatic modelWrite(input int d, input logic [6:0] seg, output logic frameDone);
      logic [5:0] r;
      r = decodeRef(seg);
      expBcd[4*d +: 4] = r[3:0];
      expBlank[d]      = r[5];
      expErr[d]        = r[4];
      expMask[d]       = 1'b1;
      frameDone        = 1'b0;
      if (expMask == 4'hF) begin
         expMask   = 4'h0;
         expFvDone++;
         frameDone = 1'b1;
      end
   endtask

   task automatic modelClear();
      expBcd   = '0;
      expBlank = '0;
      expErr   = '0;
      expMask  = '0;
   endtask

   // A pulse visible right now has not yet reached the negedge counter.
   task automatic pushExpect(input string tag, input logic fvNow);
      expT e;
      e.tag     = tag;
      e.bcd     = expBcd;
      e.blank   = expBlank;
      e.err     = expErr;
      e.fvNow   = fvNow;
      e.fvTotal = expFvDone - (fvNow ? 1 : 0);
      sbQueue.push_back(e);
   endtask

   task automatic checkOutput();
      expT e;
      if (sbQueue.size() == 0) begin
         testCount++;
         failCount++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
         return;
      end
      e = sbQueue.pop_front();
      testCount++;
      assert (bcd_out === e.bcd) else begin
         failCount++;
         $error("[TB] FAIL %s bcd_out: got %h expected %h", e.tag, bcd_out, e.bcd);
      end
      testCount++;
      assert (blank_out === e.blank) else begin
         failCount++;
         $error("[TB] FAIL %s blank_out: got %b expected %b", e.tag, blank_out, e.blank);
      end
      testCount++;
      assert (err_out === e.err) else begin
         failCount++;
         $error("[TB] FAIL %s err_out: got %b expected %b", e.tag, err_out, e.err);
      end
      testCount++;
      assert (frame_valid === e.fvNow) else begin
         failCount++;
         $error("[TB] FAIL %s frame_valid: got %b expected %b", e.tag, frame_valid, e.fvNow);
      end
      testCount++;
      assert (fvSeen === e.fvTotal) else begin
         failCount++;
         $error("[TB] FAIL %s frame pulses: got %0d expected %0d", e.tag, fvSeen, e.fvTotal);
      end
   endtask

   // Hold one digit pattern; check just before and exactly at the write edge.
   task automatic captureDigit(input int d, input logic [6:0] seg, input string tag);
      logic fd;
      applyStimulus(4'(1 << d), seg);
      pushExpect({tag, "_pre"}, 1'b0);
      modelWrite(d, seg, fd);
      pushExpect({tag, "_post"}, fd);
      tick(4);
      checkOutput();
      tick(1);
      checkOutput();
      applyStimulus(4'b0000, 7'b0000000);
      tick(3);
   endtask

   initial begin
      // Reset with random inputs on the bus and controls.
      rst_n   = 1'b0;
      en      = 1'($urandom);
      clr     = 1'($urandom);
      seg_in  = 7'($urandom);
      dig_sel = 4'($urandom);
      tick(2);
      pushExpect("reset", 1'b0);
      checkOutput();
      rst_n = 1'b1;
      en    = 1'b1;
      clr   = 1'b0;
      applyStimulus(4'b0000, 7'b0000000);
      tick(3);

      // Single digit: 2 on digit 0, written on the 5th edge.
      captureDigit(0, SEG2, "single");

      // Full frame 4,7,9,0 with each digit held 4 cycles.
      applyStimulus(4'b0001, SEG4);
      modelWrite(0, SEG4, doneFlag);
      tick(4);
      applyStimulus(4'b0010, SEG7);
      modelWrite(1, SEG7, doneFlag);
      tick(4);
      applyStimulus(4'b0100, SEG9);
      modelWrite(2, SEG9, doneFlag);
      tick(4);
      applyStimulus(4'b1000, SEG0);
      pushExpect("frame_pre", 1'b0);
      modelWrite(3, SEG0, doneFlag);
      tick(4);
      checkOutput();
      applyStimulus(4'b0000, 7'b0000000);
      pushExpect("frame_pulse", doneFlag);
      tick(1);
      checkOutput();
      pushExpect("frame_after", 1'b0);
      tick(1);
      checkOutput();
      tick(3);

      // Glitching pattern on digit 1 never settles, then a clean 6 does.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(4'b0010, (i % 2 == 0) ? SEG6 : SEG8);
         tick(1);
      end
      captureDigit(1, SEG6, "glitch");

      // Blank on digit 2, illegal on digit 3.
      captureDigit(2, 7'b0000000, "blank");
      captureDigit(3, 7'b1010101, "illegal");

      // Two selects at once: nothing may be written.
      applyStimulus(4'b0011, SEG8);
      pushExpect("nonhot", 1'b0);
      tick(10);
      checkOutput();

      // en dropped after two matching samples; one more sample commits,
      // and this write completes the frame (mask was 1110).
      applyStimulus(4'b0001, SEG5);
      pushExpect("en_hold", 1'b0);
      tick(4);
      en = 1'b0;
      tick(3);
      checkOutput();
      modelWrite(0, SEG5, doneFlag);
      pushExpect("en_resume", doneFlag);
      en = 1'b1;
      tick(1);
      checkOutput();
      pushExpect("en_after", 1'b0);
      tick(1);
      checkOutput();
      applyStimulus(4'b0000, 7'b0000000);
      tick(3);

      // clr coincident with the write that would complete a frame.
      applyStimulus(4'b0001, SEG1);
      modelWrite(0, SEG1, doneFlag);
      tick(4);
      applyStimulus(4'b0100, SEG2);
      modelWrite(2, SEG2, doneFlag);
      tick(4);
      applyStimulus(4'b1000, SEG8);
      modelWrite(3, SEG8, doneFlag);
      tick(4);
      applyStimulus(4'b0010, SEG3);
      tick(4);
      clr = 1'b1;
      applyStimulus(4'b0000, 7'b0000000);
      modelClear();
      pushExpect("clr_write", 1'b0);
      tick(1);
      clr = 1'b0;
      checkOutput();
      pushExpect("clr_after", 1'b0);
      tick(5);
      checkOutput();

      // Mask was cleared by clr, so digit 1 alone must not finish a frame.
      captureDigit(1, SEG9, "post_clr");

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
